// File: rtl/rc_adaptive_xy_if.sv
// Flit/handshake bundle between the input buffer, the route-compute stage
// and the switch allocator; pressures come from the four downstream ports.
interface rc_adaptive_xy_if #(
    parameter int DATASIZE = 40,
    parameter int WIDTH    = 3
);
    logic [DATASIZE-1:0] data_in;
    logic                valid_in;
    logic                ready_out;
    logic [WIDTH:0]      N_pressure_in;
    logic [WIDTH:0]      E_pressure_in;
    logic [WIDTH:0]      S_pressure_in;
    logic [WIDTH:0]      W_pressure_in;
    logic [DATASIZE-1:0] data_out;
    logic [3:0]          direction_out;
    logic                valid_out;
    logic                ready_in;
    logic                err_out;

    modport slave (
        input  data_in, valid_in, N_pressure_in, E_pressure_in, S_pressure_in,
               W_pressure_in, ready_in,
        output ready_out, data_out, direction_out, valid_out, err_out
    );

    modport master (
        output data_in, valid_in, N_pressure_in, E_pressure_in, S_pressure_in,
               W_pressure_in, ready_in,
        input  ready_out, data_out, direction_out, valid_out, err_out
    );
endinterface

// File: rtl/rc_adaptive_xy.sv
// Route-compute stage: XY or minimal-adaptive direction per packet, held for
// the whole wormhole, presented through a one-deep registered valid/ready stage.
module rc_adaptive_xy #(
    parameter int DATASIZE = 40,
    parameter int WIDTH    = 3,
    parameter int X_W      = 2,
    parameter int Y_W      = 2,
    parameter int DST_LSB  = 32,
    parameter int TYPE_LSB = 0,
    parameter int MY_X     = 1,
    parameter int MY_Y     = 0,
    parameter int MESH_X   = 4,
    parameter int MESH_Y   = 4,
    parameter bit ADAPTIVE = 1'b1
) (
    input logic            rc_clk,
    input logic            rst_n,
    rc_adaptive_xy_if.slave bus
);
    typedef enum logic [1:0] {FT_SINGLE = 2'b00, FT_HEAD = 2'b01, FT_BODY = 2'b10, FT_TAIL = 2'b11} flit_t;
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [3:0] DIR_W     = 4'b1000;
    localparam logic [3:0] DIR_N     = 4'b0100;
    localparam logic [3:0] DIR_E     = 4'b0010;
    localparam logic [3:0] DIR_S     = 4'b0001;
    localparam logic [3:0] DIR_LOCAL = 4'b0000;
    localparam logic [3:0] DIR_NONE  = 4'b1111;

    state_t         state, state_nxt;
    logic [3:0]     locked_dir, lock_nxt;
    logic [3:0]     route_dir, dir_sel;
    logic           route_err, err_sel;
    logic           accept;
    flit_t          ftype;
    logic [X_W-1:0] dst_x;
    logic [Y_W-1:0] dst_y;
    logic           x_gt, x_lt, y_gt, y_lt, out_of_range;
    logic [3:0]     x_dir, y_dir;
    logic [WIDTH:0] x_press, y_press;

    assign bus.ready_out = !bus.valid_out || bus.ready_in;
    assign accept        = bus.valid_in && bus.ready_out;

    assign ftype = flit_t'(bus.data_in[TYPE_LSB +: 2]);
    assign dst_x = bus.data_in[DST_LSB +: X_W];
    assign dst_y = bus.data_in[DST_LSB + X_W +: Y_W];

    assign x_gt = int'(dst_x) > MY_X;
    assign x_lt = int'(dst_x) < MY_X;
    assign y_gt = int'(dst_y) > MY_Y;
    assign y_lt = int'(dst_y) < MY_Y;
    assign out_of_range = (int'(dst_x) >= MESH_X) || (int'(dst_y) >= MESH_Y);

    // Increasing y heads south, increasing x heads east.
    assign x_dir   = x_gt ? DIR_E : DIR_W;
    assign y_dir   = y_gt ? DIR_S : DIR_N;
    assign x_press = x_gt ? bus.E_pressure_in : bus.W_pressure_in;
    assign y_press = y_gt ? bus.S_pressure_in : bus.N_pressure_in;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        route_dir = DIR_LOCAL;
        route_err = 1'b0;
        if (out_of_range) begin
            route_dir = DIR_NONE;
            route_err = 1'b1;
        end else if ((x_gt || x_lt) && (y_gt || y_lt)) begin
            route_dir = (!ADAPTIVE || x_press <= y_press) ? x_dir : y_dir;
        end else if (x_gt || x_lt) begin
            route_dir = x_dir;
        end else if (y_gt || y_lt) begin
            route_dir = y_dir;
        end
    end

    always_comb begin
        state_nxt = state;
        lock_nxt  = locked_dir;
        dir_sel   = DIR_NONE;
        err_sel   = 1'b0;
        if (accept) begin
            case (ftype)
                FT_SINGLE: begin
                    dir_sel   = route_dir;
                    err_sel   = route_err || (state == LOCKED);
                    state_nxt = IDLE;
                end
                FT_HEAD: begin
                    dir_sel   = route_dir;
                    err_sel   = route_err || (state == LOCKED);
                    lock_nxt  = route_dir;
                    state_nxt = LOCKED;
                end
                FT_BODY: begin
                    if (state == LOCKED) dir_sel = locked_dir;
                    else                 err_sel = 1'b1;
                end
                FT_TAIL: begin
                    if (state == LOCKED) begin
                        dir_sel   = locked_dir;
                        state_nxt = IDLE;
                    end else begin
                        err_sel = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge rc_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            locked_dir <= DIR_NONE;
        end else begin
            state      <= state_nxt;
            locked_dir <= lock_nxt;
        end
    end

    always_ff @(posedge rc_clk) begin
        if (!rst_n) begin
            bus.data_out      <= '0;
            bus.direction_out <= DIR_NONE;
            bus.valid_out     <= 1'b0;
            bus.err_out       <= 1'b0;
        end else begin
            bus.err_out <= accept && err_sel;
            if (accept) begin
                bus.data_out      <= bus.data_in;
                bus.direction_out <= dir_sel;
                bus.valid_out     <= 1'b1;
            end else if (bus.valid_out && bus.ready_in) begin
                bus.direction_out <= DIR_NONE;
                bus.valid_out     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rc_adaptive_xy.sv
// Scoreboard bench: XY, adaptive and 4x3-mesh instances share one stimulus;
// each accept pushes an expected flit that is compared while it is presented.
module tb_rc_adaptive_xy;
    localparam int DW = 40;
    localparam int PW = 4;
    localparam logic [1:0] T_SINGLE = 2'b00, T_HEAD = 2'b01, T_BODY = 2'b10, T_TAIL = 2'b11;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    dir;
        logic          err;
    } exp_t;

    logic          rc_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_in = 1'b1;
    logic [PW-1:0] pn = '0, pe = '0, ps = '0, pw = '0;
    bit            rand_ready = 1'b0;
    int            seq = 0;

    int checks = 0;
    int failures = 0;

    rc_adaptive_xy_if #(.DATASIZE(DW), .WIDTH(PW-1)) bus0 ();
    rc_adaptive_xy_if #(.DATASIZE(DW), .WIDTH(PW-1)) bus1 ();
    rc_adaptive_xy_if #(.DATASIZE(DW), .WIDTH(PW-1)) bus2 ();

    assign bus0.data_in = data_in;  assign bus1.data_in = data_in;  assign bus2.data_in = data_in;
    assign bus0.valid_in = valid_in; assign bus1.valid_in = valid_in; assign bus2.valid_in = valid_in;
    assign bus0.ready_in = ready_in; assign bus1.ready_in = ready_in; assign bus2.ready_in = ready_in;
    assign bus0.N_pressure_in = pn; assign bus1.N_pressure_in = pn; assign bus2.N_pressure_in = pn;
    assign bus0.E_pressure_in = pe; assign bus1.E_pressure_in = pe; assign bus2.E_pressure_in = pe;
    assign bus0.S_pressure_in = ps; assign bus1.S_pressure_in = ps; assign bus2.S_pressure_in = ps;
    assign bus0.W_pressure_in = pw; assign bus1.W_pressure_in = pw; assign bus2.W_pressure_in = pw;

    logic [DW-1:0] d_out [3];
    logic [3:0]    dir_out [3];
    logic          v_out [3], r_out [3], e_out [3];

    assign d_out[0] = bus0.data_out; assign dir_out[0] = bus0.direction_out;
    assign v_out[0] = bus0.valid_out; assign r_out[0] = bus0.ready_out; assign e_out[0] = bus0.err_out;
    assign d_out[1] = bus1.data_out; assign dir_out[1] = bus1.direction_out;
    assign v_out[1] = bus1.valid_out; assign r_out[1] = bus1.ready_out; assign e_out[1] = bus1.err_out;
    assign d_out[2] = bus2.data_out; assign dir_out[2] = bus2.direction_out;
    assign v_out[2] = bus2.valid_out; assign r_out[2] = bus2.ready_out; assign e_out[2] = bus2.err_out;

    rc_adaptive_xy #(.ADAPTIVE(1'b0)) u_xy (.rc_clk(rc_clk), .rst_n(rst_n), .bus(bus0));
    rc_adaptive_xy #(.ADAPTIVE(1'b1)) u_ad (.rc_clk(rc_clk), .rst_n(rst_n), .bus(bus1));
    rc_adaptive_xy #(.ADAPTIVE(1'b1), .MESH_Y(3)) u_m3 (.rc_clk(rc_clk), .rst_n(rst_n), .bus(bus2));

    always #5 rc_clk = ~rc_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference route for node (1,0) on a 4-column mesh; returns {err, dir}.
    function automatic logic [4:0] model_route(input int inst, input logic [DW-1:0] f);
        int x, y, dx, dy, px, py, mesh_y;
        logic [3:0] xd, yd;
        x = int'(f[33:32]);
        y = int'(f[35:34]);
        mesh_y = (inst == 2) ? 3 : 4;
        if (x >= 4 || y >= mesh_y) return {1'b1, 4'b1111};
        dx = x - 1;
        dy = y;
        if (dx == 0 && dy == 0) return 5'b0_0000;
        xd = (dx > 0) ? 4'b0010 : 4'b1000;
        yd = (dy > 0) ? 4'b0001 : 4'b0100;
        px = (dx > 0) ? int'(pe) : int'(pw);
        py = (dy > 0) ? int'(ps) : int'(pn);
        if (dx == 0) return {1'b0, yd};
        if (dy == 0 || inst == 0 || px <= py) return {1'b0, xd};
        return {1'b0, yd};
    endfunction

    exp_t       q [3][$];
    bit         m_locked [3];
    logic [3:0] m_lock [3];
    bit         fresh [3];
    bit         started = 1'b0;
    bit         after_rst = 1'b0;

    always @(negedge rc_clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("valid%0d", i), v_out[i], q[i].size() != 0);
                check($sformatf("ready%0d", i), r_out[i], (q[i].size() == 0) || ready_in);
                check($sformatf("err%0d", i), e_out[i], fresh[i] ? q[i][0].err : 1'b0);
                if (q[i].size() != 0) begin
                    check($sformatf("data%0d", i), d_out[i], q[i][0].data);
                    check($sformatf("dir%0d", i), dir_out[i], q[i][0].dir);
                end else begin
                    check($sformatf("idle_dir%0d", i), dir_out[i], 4'b1111);
                end
                if (after_rst) check($sformatf("rst_data%0d", i), d_out[i], '0);
            end
        end
        after_rst = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                q[i].delete();
                m_locked[i] = 1'b0;
                m_lock[i]   = 4'b1111;
                fresh[i]    = 1'b0;
            end
            started   = 1'b1;
            after_rst = 1'b1;
        end else if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic acc;
                logic [4:0] r;
                exp_t e;
                acc = valid_in && ((q[i].size() == 0) || ready_in);
                if (q[i].size() != 0 && ready_in) void'(q[i].pop_front());
                fresh[i] = acc;
                if (acc) begin
                    r = model_route(i, data_in);
                    e.data = data_in;
                    e.dir  = 4'b1111;
                    e.err  = 1'b0;
                    case (data_in[1:0])
                        T_SINGLE: begin e.dir = r[3:0]; e.err = r[4] | m_locked[i]; m_locked[i] = 1'b0; end
                        T_HEAD: begin
                            e.dir = r[3:0]; e.err = r[4] | m_locked[i];
                            m_locked[i] = 1'b1; m_lock[i] = r[3:0];
                        end
                        default: begin
                            if (m_locked[i]) e.dir = m_lock[i];
                            else             e.err = 1'b1;
                            if (data_in[1:0] == T_TAIL) m_locked[i] = 1'b0;
                        end
                    endcase
                    q[i].push_back(e);
                end
            end
        end
    end

    always @(posedge rc_clk) begin
        if (rand_ready) begin
            #1;
            ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic set_p(input logic [PW-1:0] n, e, s, w);
        pn = n; pe = e; ps = s; pw = w;
    endtask

    // Drives one flit and returns once it is accepted; waited = stall cycles.
    task automatic send(input logic [1:0] t, input logic [3:0] dst, output int waited);
        bit ok;
        data_in  = {4'h0, dst, 30'(seq), t};
        seq++;
        valid_in = 1'b1;
        waited   = 0;
        ok       = 1'b0;
        while (!ok) begin
            @(negedge rc_clk);
            ok = bus1.ready_out;
            @(posedge rc_clk);
            #1;
            if (!ok) begin
                waited++;
                if (waited > 50) begin
                    check("send_timeout", bus1.ready_out, 1'b1);
                    break;
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge rc_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);

        // Deterministic single flits: W, local, E.
        send(T_SINGLE, 4'b0000, w);
        send(T_SINGLE, 4'b0001, w);
        send(T_SINGLE, 4'b0010, w);
        cycles(2);

        // Adaptive choice between W and S for (0,1).
        set_p(4'd0, 4'd0, 4'd5, 4'd2); send(T_SINGLE, 4'b0100, w);
        set_p(4'd0, 4'd0, 4'd5, 4'd6); send(T_SINGLE, 4'b0100, w);
        set_p(4'd0, 4'd0, 4'd3, 4'd3); send(T_SINGLE, 4'b0100, w);
        cycles(1);

        // Wormhole lock survives pressure swap; next head re-routes.
        set_p(4'd0, 4'd7, 4'd1, 4'd0); send(T_HEAD, 4'b0110, w);
        set_p(4'd0, 4'd1, 4'd7, 4'd0); send(T_BODY, 4'b0110, w);
        send(T_TAIL, 4'b0110, w);
        send(T_HEAD, 4'b0110, w);
        send(T_BODY, 4'b0000, w);
        send(T_TAIL, 4'b0000, w);
        cycles(1);

        // Backpressure: second flit stalls three cycles behind a held output.
        ready_in = 1'b0;
        send(T_SINGLE, 4'b0010, w);
        fork
            send(T_SINGLE, 4'b0000, w);
            begin cycles(3); ready_in = 1'b1; end
        join
        check("stall_cycles", w, 3);
        for (int i = 0; i < 6; i++) begin
            set_p(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            send(T_SINGLE, 4'($urandom_range(0, 15)), w);
            check("throughput", w, 0);
        end
        cycles(2);

        // Errors: stray body, out-of-range y on the 3-row instance, held err pulse.
        ready_in = 1'b0;
        send(T_BODY, 4'b0010, w);
        cycles(2);
        ready_in = 1'b1;
        send(T_SINGLE, 4'b1101, w);
        send(T_HEAD, 4'b1110, w);
        send(T_BODY, 4'b0000, w);
        send(T_SINGLE, 4'b0011, w);
        cycles(2);

        // Reset while locked with a held flit discards both.
        set_p(4'd0, 4'd7, 4'd1, 4'd0);
        ready_in = 1'b0;
        send(T_HEAD, 4'b0110, w);
        cycles(1);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        ready_in = 1'b1;
        send(T_BODY, 4'b0110, w);
        cycles(2);

        // Random traffic with random downstream readiness.
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            set_p(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), w);
            if ($urandom_range(0, 3) == 0) cycles(1);
        end
        rand_ready = 1'b0;
        cycles(1);
        ready_in = 1'b1;
        cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rc_adaptive_xy.md
Name: rc_adaptive_xy

Overview:
- Parametrised route-computation stage for one input port of a mesh router; replaces the per-node hard-coded RC tables.
- Decodes destination coordinates from each head flit against compile-time node coordinates and picks an output direction: deterministic XY, or minimal-adaptive using downstream pressure.
- Holds the chosen direction for the rest of the wormhole packet (body/tail flits) and presents flit + direction to the switch allocator through a one-deep registered valid/ready stage.

Parameters:
- DATASIZE, 40, flit width.
- WIDTH, 3, pressure counter width minus 1 (pressure inputs are WIDTH+1 bits).
- X_W, 2, x-coordinate bits.
- Y_W, 2, y-coordinate bits.
- DST_LSB, 32, LSB of destination field; dst = flit[DST_LSB +: X_W+Y_W], x in low bits, y in high bits.
- TYPE_LSB, 0, LSB of 2-bit flit type field.
- MY_X, 1, this node x.
- MY_Y, 0, this node y.
- MESH_X, 4, columns.
- MESH_Y, 4, rows.
- ADAPTIVE, 1, 0 = XY deterministic, 1 = minimal adaptive.

Ports:
- rc_clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- data_in  input  DATASIZE  flit from input buffer
- valid_in  input  1  data_in valid
- ready_out  output  1  stage can accept flit
- N_pressure_in  input  WIDTH+1  north downstream occupancy
- E_pressure_in  input  WIDTH+1  east downstream occupancy
- S_pressure_in  input  WIDTH+1  south downstream occupancy
- W_pressure_in  input  WIDTH+1  west downstream occupancy
- data_out  output  DATASIZE  registered flit
- direction_out  output  4  {W,N,E,S} one-hot; 4'b0000 = local, 4'b1111 = none/invalid
- valid_out  output  1  data_out/direction_out valid
- ready_in  input  1  allocator accepts flit
- err_out  output  1  one-cycle pulse on protocol/address error

Behaviour:
- Reset (rst_n low at rc_clk rising edge): data_out = 0, direction_out = 4'b1111, valid_out = 0, err_out = 0, FSM = IDLE, locked_dir = 4'b1111. Reset mid-packet discards lock and output flit.
- Flit types (flit[TYPE_LSB+1:TYPE_LSB]): 00 single, 01 head, 10 body, 11 tail.
- Handshake: ready_out = !valid_out | ready_in (combinational). Accept = valid_in & ready_out. Transfer out = valid_out & ready_in.
- On accept, data_out, direction_out, and valid_out = 1 load next cycle (latency 1). Transfer without accept sets valid_out = 0 and direction_out = 4'b1111. Outputs hold while valid_out & !ready_in.
- Route compute, dx = dst_x - MY_X, dy = dst_y - MY_Y (signed compare):
  - dx = dy = 0: 4'b0000.
  - ADAPTIVE = 0: dx ≠ 0 → E (dx > 0) or W; else S (dy > 0) or N.
  - ADAPTIVE = 1, one axis nonzero: that axis direction. Both nonzero: compare the x-candidate pressure with the y-candidate pressure (unsigned); x wins if ≤ (tie → x).
  - dst_x ≥ MESH_X or dst_y ≥ MESH_Y: direction 4'b1111, err_out pulse.
- Pressure is sampled only in the accept cycle of a head/single flit.
- FSM:
  - IDLE: single accepted → route, stay IDLE.
  - IDLE: head accepted → route, locked_dir = result, go LOCKED.
  - IDLE: body/tail accepted → direction 4'b1111, err_out, stay IDLE.
  - LOCKED: body accepted → direction = locked_dir, stay.
  - LOCKED: tail accepted → direction = locked_dir, go IDLE.
  - LOCKED: head/single accepted → err_out, re-route as a new packet (head → stay LOCKED with new lock; single → IDLE).
- Head with out-of-range dst: locked_dir = 4'b1111, so the whole packet carries 4'b1111.
- No accept: FSM and lock unchanged; valid_in low never changes state.

Test Plan:
- XY, MY = (1,0): single with dst 4'b0000 → direction_out 4'b1000, valid_out next cycle; dst 4'b0001 → 4'b0000; dst 4'b0010 → 4'b0010.
- Adaptive, dst 4'b0100 (x=0,y=1): W = 2, S = 5 → 4'b1000; W = 6, S = 5 → 4'b0001; W = S = 3 → 4'b1000 (tie).
- Wormhole: head dst 4'b0110 with E = 7, S = 1 → 4'b0001; then pressures swap, and body and tail → 4'b0001. Then a new head re-routes → 4'b0010.
- Backpressure: ready_in = 0 for 3 cycles with valid_out = 1 → data_out/direction_out stable, ready_out = 0, no flit lost. ready_in = 1 with valid_in = 1 → back-to-back throughput of 1 flit/cycle.
- Errors: body in IDLE → 4'b1111 and err_out for 1 cycle. dst_y = 3 with MESH_Y = 3 → 4'b1111 and err_out.
- rst_n low for 1 cycle while LOCKED with valid_out = 1 → valid_out = 0, direction_out = 4'b1111. Next body → 4'b1111 and err_out.
